// File: rtl/writeback_seq_ctrl.sv
// rtl/writeback_seq_ctrl.sv - write-back sequencer: MemToReg select, register-file write strobe, load handshake
//
// Purpose:
//   Accepts one instruction at a time from decode/execute and sequences its
//   write-back. ALU ops write AluResult one cycle after accept. Loads issue a
//   held MemReq until MemReady, then write MemReadData. Busy stalls upstream
//   whenever the sequencer is not idle.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   InstValid, IsLoad, RegWriteIn,   instruction handshake and decoded controls
//   WriteRegIn, AluResult
//   MemReadData, MemReady            data-memory response
//   MemReq, MemAddr                  data-memory request
//   MemToReg, RegWrite, WriteReg,    write-back mux select, register-file write port
//   WbData
//   Busy                             upstream stall
//   LoadErr                          one-cycle load-timeout pulse
//
// Configuration:
//   WB_TIMEOUT_EN  when defined, a load waiting TIMEOUT_CYCLES cycles without
//                  MemReady is aborted and LoadErr pulses; otherwise MEM_WAIT
//                  waits indefinitely and LoadErr is tied low.

module writeback_seq_ctrl #(
    parameter int DATA_W         = 32,
    parameter int REG_ADDR_W     = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  InstValid,
    input  logic                  IsLoad,
    input  logic                  RegWriteIn,
    input  logic [REG_ADDR_W-1:0] WriteRegIn,
    input  logic [DATA_W-1:0]     AluResult,
    input  logic [DATA_W-1:0]     MemReadData,
    input  logic                  MemReady,
    output logic                  MemReq,
    output logic [DATA_W-1:0]     MemAddr,
    output logic                  MemToReg,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0]     WbData,
    output logic                  Busy,
    output logic                  LoadErr
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MEM_WAIT  = 2'd1,
        S_WRITEBACK = 2'd2
    } state_t;

    // A timeout shorter than two cycles would abort a load before memory
    // could ever answer.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       mem_addr_q, mem_addr_d;
    logic                    mem_to_reg_q, mem_to_reg_d;
    logic [DATA_W-1:0]       wb_data_q, wb_data_d;
    logic [REG_ADDR_W-1:0]   write_reg_q, write_reg_d;
    logic                    reg_write_en_q, reg_write_en_d;

    logic accept;
    logic timeout;

    assign accept = InstValid && (state_q == S_IDLE);

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_err_q, load_err_d;

    // MemReady in the final wait cycle takes priority over the abort.
    assign timeout = (state_q == S_MEM_WAIT) && !MemReady &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (accept && IsLoad) begin
            cnt_d = '0;
        end else if (state_q == S_MEM_WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        load_err_d = timeout;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            load_err_q <= load_err_d;
        end
    end

    assign LoadErr = load_err_q;
`else
    assign timeout = 1'b0;
    assign LoadErr = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (IsLoad) begin
                        state_d = S_MEM_WAIT;
                    end else if (RegWriteIn) begin
                        state_d = S_WRITEBACK;
                    end
                end
            end
            S_MEM_WAIT: begin
                if (MemReady) begin
                    state_d = S_WRITEBACK;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_WRITEBACK: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; Busy has no path from InstValid.
    always_comb begin
        MemReq   = 1'b0;
        Busy     = 1'b0;
        RegWrite = 1'b0;
        case (state_q)
            S_MEM_WAIT: begin
                MemReq = 1'b1;
                Busy   = 1'b1;
            end
            S_WRITEBACK: begin
                Busy     = 1'b1;
                // Register 0 is hard-wired, so writes to it are dropped.
                RegWrite = reg_write_en_q && (write_reg_q != '0);
            end
            default: ;
        endcase
    end

    // Captured operands and write-back data. WbData/MemToReg keep their last
    // value until a new write-back source is selected.
    always_comb begin
        mem_addr_d     = mem_addr_q;
        mem_to_reg_d   = mem_to_reg_q;
        wb_data_d      = wb_data_q;
        write_reg_d    = write_reg_q;
        reg_write_en_d = reg_write_en_q;
        if (accept) begin
            if (IsLoad) begin
                mem_addr_d     = AluResult;
                write_reg_d    = WriteRegIn;
                reg_write_en_d = RegWriteIn;
            end else if (RegWriteIn) begin
                wb_data_d      = AluResult;
                mem_to_reg_d   = 1'b0;
                write_reg_d    = WriteRegIn;
                reg_write_en_d = 1'b1;
            end
        end
        if ((state_q == S_MEM_WAIT) && MemReady) begin
            wb_data_d    = MemReadData;
            mem_to_reg_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q     <= '0;
            mem_to_reg_q   <= 1'b0;
            wb_data_q      <= '0;
            write_reg_q    <= '0;
            reg_write_en_q <= 1'b0;
        end else begin
            mem_addr_q     <= mem_addr_d;
            mem_to_reg_q   <= mem_to_reg_d;
            wb_data_q      <= wb_data_d;
            write_reg_q    <= write_reg_d;
            reg_write_en_q <= reg_write_en_d;
        end
    end

    assign MemAddr  = mem_addr_q;
    assign MemToReg = mem_to_reg_q;
    assign WbData   = wb_data_q;
    assign WriteReg = write_reg_q;

endmodule

// File: tb/tb_writeback_seq_ctrl.sv
// tb/tb_writeback_seq_ctrl.sv - scoreboard bench for writeback_seq_ctrl
`timescale 1ns/1ps
module tb_writeback_seq_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          InstValid, IsLoad, RegWriteIn, MemReady;
    logic [AW-1:0] WriteRegIn;
    logic [DW-1:0] AluResult, MemReadData;
    logic          MemReq, MemToReg, RegWrite, Busy, LoadErr;
    logic [DW-1:0] MemAddr, WbData;
    logic [AW-1:0] WriteReg;

    always #5 clk = ~clk;

    writeback_seq_ctrl #(.DATA_W(DW), .REG_ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .InstValid(InstValid), .IsLoad(IsLoad),
        .RegWriteIn(RegWriteIn), .WriteRegIn(WriteRegIn), .AluResult(AluResult),
        .MemReadData(MemReadData), .MemReady(MemReady), .MemReq(MemReq),
        .MemAddr(MemAddr), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .WriteReg(WriteReg), .WbData(WbData), .Busy(Busy), .LoadErr(LoadErr)
    );

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        logic          m2r;
        int            at;
    } wr_t;

    typedef struct {
        bit            is_load;
        bit            rw;
        logic [AW-1:0] rd;
        logic [DW-1:0] alu;
        logic [DW-1:0] mem;
        int            delay;
        bit            hold;
    } inst_t;

    wr_t   exp_q[$];
    wr_t   e;
    inst_t prog[$];

    int checks = 0, failures = 0;
    int cyc = 0;
    int writes_seen = 0, writes_exp = 0;
    bit mon_en = 0;
    bit exp_busy = 0, exp_memreq = 0, exp_loaderr = 0, exp_m2r = 0;
    logic [DW-1:0] exp_addr = '0, exp_wb = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares DUT outputs to the model state each cycle and pops
    // the scoreboard whenever a register-file write appears.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("Busy", DW'(Busy), DW'(exp_busy));
            chk("MemReq", DW'(MemReq), DW'(exp_memreq));
            chk("LoadErr", DW'(LoadErr), DW'(exp_loaderr));
            chk("MemToReg_hold", DW'(MemToReg), DW'(exp_m2r));
            chk("WbData_hold", WbData, exp_wb);
            if (exp_memreq) chk("MemAddr", MemAddr, exp_addr);
            if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_write: no RegWrite seen, required reg %0d at cycle %0d", e.rd, e.at);
            end
            if (RegWrite === 1'b1) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: RegWrite=1 WriteReg=%0d required no write (cycle %0d)", WriteReg, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("WriteReg", DW'(WriteReg), DW'(e.rd));
                    chk("WbData", WbData, e.data);
                    chk("MemToReg", DW'(MemToReg), DW'(e.m2r));
                    chk("write_cycle", DW'(cyc), DW'(e.at));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_write(input logic [AW-1:0] rd, input logic [DW-1:0] d, input logic m, input int at);
        wr_t w;
        w.rd = rd; w.data = d; w.m2r = m; w.at = at;
        exp_q.push_back(w);
        writes_exp++;
    endtask

    task automatic present(input inst_t n, input bit valid);
        InstValid  = valid;
        IsLoad     = n.is_load;
        RegWriteIn = n.rw;
        WriteRegIn = n.rd;
        AluResult  = n.alu;
    endtask

    task automatic zero_model();
        exp_busy = 0; exp_memreq = 0; exp_loaderr = 0; exp_m2r = 0; exp_wb = '0;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs();
        chk("rst_MemReq", DW'(MemReq), '0);
        chk("rst_MemAddr", MemAddr, '0);
        chk("rst_MemToReg", DW'(MemToReg), '0);
        chk("rst_RegWrite", DW'(RegWrite), '0);
        chk("rst_WriteReg", DW'(WriteReg), '0);
        chk("rst_WbData", WbData, '0);
        chk("rst_Busy", DW'(Busy), '0);
        chk("rst_LoadErr", DW'(LoadErr), '0);
    endtask

    // Called one step after an edge with the sequencer idle; returns one step
    // after the edge at which it is idle again. While busy, the next
    // instruction is shown with InstValid = n.hold and must not be accepted.
    task automatic run_inst(input inst_t c, input inst_t n);
        int k, m;
        present(c, 1'b1);
        MemReady    = 1'($urandom_range(0, 1));
        MemReadData = $urandom;
        tick();
        k = cyc;
        present(n, n.hold);
        if (!c.is_load) begin
            if (c.rw) begin
                exp_busy = 1;
                exp_wb   = c.alu;
                exp_m2r  = 0;
                if (c.rd != '0) push_write(c.rd, c.alu, 1'b0, k);
                tick();
                exp_busy = 0;
            end
        end else begin
            exp_busy   = 1;
            exp_memreq = 1;
            exp_addr   = c.alu;
            MemReady   = 1'b0;
            repeat (c.delay) tick();
            MemReady    = 1'b1;
            MemReadData = c.mem;
            tick();
            m = cyc;
            MemReady    = 1'($urandom_range(0, 1));
            MemReadData = $urandom;
            exp_memreq  = 0;
            exp_wb      = c.mem;
            exp_m2r     = 1;
            if (c.rw && c.rd != '0) push_write(c.rd, c.mem, 1'b1, m);
            tick();
            exp_busy = 0;
        end
    endtask

    function automatic inst_t mk(input bit ld, input bit rw, input int rd, input logic [DW-1:0] alu,
                                 input logic [DW-1:0] mem, input int dly, input bit hold);
        inst_t i;
        i.is_load = ld; i.rw = rw; i.rd = AW'(rd); i.alu = alu; i.mem = mem; i.delay = dly; i.hold = hold;
        return i;
    endfunction

    initial begin
        inst_t idle_i, c;
        int kind;
        idle_i = mk(0, 0, 0, '0, '0, 0, 0);
        reset = 1'b1; InstValid = 0; IsLoad = 0; RegWriteIn = 0; WriteRegIn = '0;
        AluResult = '0; MemReadData = '0; MemReady = 0;
        tick();
        tick();
        zero_model();
        check_reset_outputs();
        mon_en = 1;
        reset = 1'b0;
        tick();

        // Directed: ALU write, 3-cycle load, held back-to-back, zero reg, no-op
        prog.push_back(mk(0, 1, 5, 32'd432, '0, 0, 0));
        prog.push_back(mk(1, 1, 7, 32'h40, 32'd984, 2, 0));
        prog.push_back(mk(1, 1, 3, 32'h80, 32'd1234, 1, 0));
        prog.push_back(mk(0, 1, 9, 32'd342, '0, 0, 1));
        prog.push_back(mk(0, 1, 0, 32'd77, '0, 0, 0));
        prog.push_back(mk(0, 0, 4, 32'd55, '0, 0, 0));
        prog.push_back(mk(1, 0, 6, 32'h1c, 32'd99, 0, 0));
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 4);
            c = mk(kind >= 3, kind != 2, $urandom_range(0, 31), $urandom, $urandom,
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if (kind == 4 && $urandom_range(0, 3) == 0) c.rw = 0;
            prog.push_back(c);
        end

        for (int i = 0; i < prog.size(); i++) begin
            c = (i + 1 < prog.size()) ? prog[i + 1] : idle_i;
            run_inst(prog[i], c);
            if (!c.hold) begin
                InstValid = 0;
                repeat ($urandom_range(0, 2)) begin
                    MemReady = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        end
        InstValid = 0;
        tick();

        // Reset during MEM_WAIT: request drops, later MemReady is ignored
        present(mk(1, 1, 12, 32'h200, '0, 0, 0), 1'b1);
        MemReady = 0;
        tick();
        InstValid  = 0;
        exp_busy   = 1;
        exp_memreq = 1;
        exp_addr   = 32'h200;
        tick();
        reset = 1'b1;
        tick();
        zero_model();
        check_reset_outputs();
        reset = 1'b0;
        MemReady = 1'b1;
        MemReadData = 32'hdead;
        repeat (3) tick();
        MemReady = 1'b0;

`ifdef WB_TIMEOUT_EN
        // Timeout: no MemReady for TO wait cycles
        present(mk(1, 1, 11, 32'h300, '0, 0, 0), 1'b1);
        tick();
        InstValid  = 0;
        exp_busy   = 1;
        exp_memreq = 1;
        exp_addr   = 32'h300;
        repeat (TO) tick();
        exp_busy    = 0;
        exp_memreq  = 0;
        exp_loaderr = 1;
        tick();
        exp_loaderr = 0;
        tick();
        // MemReady on the final wait cycle wins over the timeout
        run_inst(mk(1, 1, 13, 32'h304, 32'd4321, TO - 1, 0), idle_i);
        InstValid = 0;
        tick();
`endif

        repeat (3) tick();
        chk("pending_writes", DW'(exp_q.size()), '0);
        chk("write_count", DW'(writes_seen), DW'(writes_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
